// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per stage, registered inter-slice carry.
// Define PIPE_CLA_FLAGS_EN to build the ovf/zero flag logic; otherwise both flags are tied to 0.
module pipe_cla_addsub #(
   parameter int WIDTH  = 32,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW = WIDTH / STAGES;
   localparam int NG = SW / GROUP;

   if ((WIDTH % (STAGES * GROUP)) != 0) begin : g_bad_cfg
      $error("pipe_cla_addsub: WIDTH must be a multiple of STAGES*GROUP");
   end

   // Returns {carry_out, slice_sum}; carries inside a group come from the group's g/p prefix,
   // group carries ripple from one group to the next.
   function automatic logic [SW:0] cla_slice(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y,
                                             input logic          ci);
      logic [SW-1:0] g;
      logic [SW-1:0] p;
      logic [SW:0]   c;
      logic          cg;
      logic          gg;
      logic          pg;
      int unsigned   idx;
      g  = '0;
      p  = '0;
      c  = '0;
      cg = ci;
      for (int unsigned grp = 0; grp < NG; grp++) begin
         gg = 1'b0;
         pg = 1'b1;
         for (int unsigned j = 0; j < GROUP; j++) begin
            idx    = grp * GROUP + j;
            g[idx] = x[idx] & y[idx];
            p[idx] = x[idx] ^ y[idx];
            c[idx] = gg | (pg & cg);
            gg     = g[idx] | (p[idx] & gg);
            pg     = pg & p[idx];
         end
         cg = gg | (pg & cg);
      end
      c[SW] = cg;
      return {c[SW], p ^ c[SW-1:0]};
   endfunction

   logic             adv;
   logic [WIDTH-1:0] bo;
   logic             c0;

   // Whole pipeline advances together; only the output stage can stall it.
   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign bo       = sub ? ~b : b;
   assign c0       = cin ^ sub;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO = k * SW;
      localparam int YW = WIDTH - k * SW;

      logic             v_in;
      logic             c_in;
      logic [WIDTH-1:0] x_in;
      logic [YW-1:0]    y_in;
      logic [SW:0]      r;
      logic [WIDTH-1:0] x_d;
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] x_q;

      // x carries finished sum slices below LO and untouched A bits above; y keeps only unconsumed B bits.
      if (k == 0) begin : g_src
         assign v_in = in_valid;
         assign x_in = a;
         assign y_in = bo;
         assign c_in = c0;
      end else begin : g_src
         assign v_in = g_stage[k-1].v_q;
         assign x_in = g_stage[k-1].x_q;
         assign y_in = g_stage[k-1].g_tail.y_q;
         assign c_in = g_stage[k-1].c_q;
      end

      assign r = cla_slice(x_in[LO +: SW], y_in[SW-1:0], c_in);

      always_comb begin
         x_d            = x_in;
         x_d[LO +: SW]  = r[SW-1:0];
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            x_q <= '0;
         end else if (adv) begin
            v_q <= v_in;
            c_q <= r[SW];
            x_q <= x_d;
         end
      end

      if (k < STAGES - 1) begin : g_tail
         logic [YW-SW-1:0] y_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               y_q <= '0;
            end else if (adv) begin
               y_q <= y_in[YW-1:SW];
            end
         end
      end else begin : g_out
         assign out_valid = v_q;
         assign sum       = x_q;
         assign cout      = c_q;
`ifdef PIPE_CLA_FLAGS_EN
         logic ovf_d;
         logic zero_d;
         logic ovf_q;
         logic zero_q;

         // a_msb ^ b_msb ^ sum_msb recovers the carry into the MSB.
         assign ovf_d  = x_in[WIDTH-1] ^ y_in[YW-1] ^ x_d[WIDTH-1] ^ r[SW];
         assign zero_d = ~|x_d;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ovf_q  <= 1'b0;
               zero_q <= 1'b0;
            end else if (adv) begin
               ovf_q  <= ovf_d;
               zero_q <= zero_d;
            end
         end

         assign ovf  = ovf_q;
         assign zero = zero_q;
`else
         assign ovf  = 1'b0;
         assign zero = 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Self-checking bench for pipe_cla_addsub (WIDTH=32, GROUP=4, STAGES=2) against an arithmetic reference model.
// Flag expectations follow PIPE_CLA_FLAGS_EN as defined for the build.
module tb_pipe_cla_addsub;

   localparam int W = 32;
`ifdef PIPE_CLA_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] s;
      logic        c;
      logic        o;
      logic        z;
   } res_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic        c;
   } op_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         sub;
   logic         cin;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int   checks = 0;
   int   errors = 0;
   int   n_out  = 0;
   bit   accepted;
   res_t expq[$];
   op_t  pending[$];

   bit          d_on;
   string       d_tag;
   logic [31:0] d_s;
   logic        d_c;
   logic        d_o;
   logic        d_z;

   pipe_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .sub      (sub),
      .cin      (cin),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .sum      (sum),
      .cout     (cout),
      .ovf      (ovf),
      .zero     (zero)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference: plain signed/unsigned arithmetic on 64-bit integers.
   function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                  input logic s, input logic ci);
      res_t   r;
      longint tot;
      longint ut;
      if (s) begin
         tot = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
         ut  = longint'(x) - longint'(y) - longint'(ci);
         r.c = (ut >= 0);
      end else begin
         tot = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
         ut  = longint'(x) + longint'(y) + longint'(ci);
         r.c = (ut >= 64'sd4294967296);
      end
      r.s = tot[31:0];
      r.o = FLAGS && ((tot > 64'sd2147483647) || (tot < -64'sd2147483648));
      r.z = FLAGS && (r.s == 32'd0);
      return r;
   endfunction

   function automatic logic [31:0] rand_word();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         4:       return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   function automatic op_t rand_op();
      op_t o;
      o.a = rand_word();
      o.b = rand_word();
      o.s = 1'($urandom_range(0, 1));
      o.c = 1'($urandom_range(0, 1));
      return o;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_op(input op_t o);
      a   = o.a;
      b   = o.b;
      sub = o.s;
      cin = o.c;
   endtask

   // One clock: observe at the falling edge, score transfers, return just after the rising edge.
   task automatic cycle(input bit stall);
      res_t e;
      @(negedge clk);
      if (out_ready) chk("in_ready_free", in_ready, 1'b1);
      if (stall) begin
         chk("stall_in_ready", in_ready, 1'b0);
         chk("stall_out_valid", out_valid, 1'b1);
         if (expq.size() > 0) begin
            e = expq[0];
            chk("hold_sum", sum, e.s);
            chk("hold_cout", cout, e.c);
            chk("hold_ovf", ovf, e.o);
            chk("hold_zero", zero, e.z);
         end
      end
      if (d_on) begin
         chk({d_tag, "_valid"}, out_valid, 1'b1);
         chk({d_tag, "_sum"}, sum, d_s);
         chk({d_tag, "_cout"}, cout, d_c);
         chk({d_tag, "_ovf"}, ovf, FLAGS & d_o);
         chk({d_tag, "_zero"}, zero, FLAGS & d_z);
      end
      if (out_valid && out_ready) begin
         chk("out_has_model", expq.size() > 0, 1'b1);
         if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("out_sum", sum, e.s);
            chk("out_cout", cout, e.c);
            chk("out_ovf", ovf, e.o);
            chk("out_zero", zero, e.z);
            n_out++;
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) expq.push_back(model(a, b, sub, cin));
      @(posedge clk);
      #1;
   endtask

   // Single operation into an empty pipeline, checking latency and the listed result.
   task automatic directed(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic s, input logic ci, input logic [31:0] es,
                           input logic ec, input logic eo, input logic ez);
      int n0;
      n0 = n_out;
      a = x; b = y; sub = s; cin = ci;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      cycle(1'b0);
      chk({tag, "_accepted"}, accepted, 1'b1);
      in_valid = 1'b0;
      @(negedge clk);
      chk({tag, "_latency"}, out_valid, 1'b0);
      @(posedge clk);
      #1;
      d_tag = tag; d_s = es; d_c = ec; d_o = eo; d_z = ez;
      d_on  = 1'b1;
      cycle(1'b0);
      d_on  = 1'b0;
      chk({tag, "_count"}, n_out - n0, 1);
   endtask

   initial begin
      int n0;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0; d_on = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_sum", sum, 32'h0);
      chk("rst_cout", cout, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_zero", zero, 1'b0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("in_ready_after_rst", in_ready, 1'b1);
      @(posedge clk);
      #1;

      directed("wrap",      32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
      directed("slice_cy",  32'h0000_FFFF, 32'h1, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0);
      directed("ovf_add",   32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
      directed("ovf_sub",   32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
      directed("sub_neg",   32'h5,         32'h7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
      directed("sub_borr",  32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
      directed("add_cin",   32'h1,         32'h1, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0, 1'b0);

      // Back-to-back stream with a 3-cycle downstream stall.
      n0 = n_out;
      repeat (8) pending.push_back(rand_op());
      for (int cyc = 0; cyc < 60 && (pending.size() > 0 || expq.size() > 0); cyc++) begin
         in_valid = (pending.size() > 0);
         if (pending.size() > 0) drive_op(pending[0]);
         out_ready = !(cyc >= 4 && cyc <= 6);
         cycle(cyc >= 4 && cyc <= 6);
         if (accepted) void'(pending.pop_front());
      end
      in_valid = 1'b0;
      chk("stream_count", n_out - n0, 8);
      chk("stream_drained", pending.size() + expq.size(), 0);

      // Random valid/ready traffic with bubbles.
      n0 = n_out;
      repeat (40) pending.push_back(rand_op());
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 600 && (pending.size() > 0 || expq.size() > 0); cyc++) begin
         if (!in_valid || accepted)
            in_valid = (pending.size() > 0) && ($urandom_range(0, 3) != 0);
         if (pending.size() > 0) drive_op(pending[0]);
         out_ready = ($urandom_range(0, 3) != 0);
         cycle(1'b0);
         if (accepted) void'(pending.pop_front());
      end
      in_valid = 1'b0;
      chk("random_count", n_out - n0, 40);
      chk("random_drained", pending.size() + expq.size(), 0);

      // Reset with two operations in flight.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_op('{a: 32'h1234_5678, b: 32'h1111_1111, s: 1'b0, c: 1'b0});
      cycle(1'b0);
      chk("inflight1_acc", accepted, 1'b1);
      drive_op('{a: 32'h0, b: 32'h0, s: 1'b0, c: 1'b0});
      cycle(1'b0);
      chk("inflight2_acc", accepted, 1'b1);
      in_valid = 1'b0;
      chk("pre_rst_valid", out_valid, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_sum", sum, 32'h0);
      chk("midrst_cout", cout, 1'b0);
      chk("midrst_ovf", ovf, 1'b0);
      chk("midrst_zero", zero, 1'b0);
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_idle", out_valid, 1'b0);
      directed("post_rst", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      chk("final_drained", expq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
